// File: rtl/adc_scan_reader_if.sv
// DSP-side read port of the ADC scan reader: strobe and address in, read data and valid out.
interface adc_scan_reader_if;
   logic        read_qualified;
   logic [7:0]  ab;
   logic [15:0] db_out;
   logic        data_from_adc_avail;

   modport master (output read_qualified, ab, input db_out, data_from_adc_avail);
   modport slave  (input read_qualified, ab, output db_out, data_from_adc_avail);
endinterface

// File: rtl/adc_scan_reader.sv
// Round-robin scanner for eight 12-bit serial ADCs: one 16-bit SPI frame per channel,
// latest sample and a fresh flag kept per channel, served through combinational bus reads.
module adc_scan_reader #(
   parameter int unsigned CLK_DIV         = 4,
   parameter int unsigned SCAN_GAP        = 16,
   parameter logic [3:0]  ADC_ADDR_NIBBLE = 4'hB
) (
   input  logic             xclk,
   input  logic             reset,
   input  logic             scan_enable,
   adc_scan_reader_if.slave bus,
   output logic             adc_sclk,
   output logic [7:0]       adc_cs_n,
   input  logic             adc_miso,
   output logic [3:0]       testpoint
);

   typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, STORE, GAP} state_e;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_LAST = 8'(SCAN_GAP - 1);

   state_e      state_q;
   logic [7:0]  cnt_q;
   logic [4:0]  half_q;
   logic [2:0]  ptr_q;
   logic [11:0] shift_q;
   logic        sclk_q;
   logic [7:0]  cs_n_q;
   logic [11:0] sample_q [8];
   logic [7:0]  fresh_q;
   logic [7:0]  fresh_d;
   logic [1:0]  miso_sync_q;
   logic        miso_sync;

   logic        rd_hit;
   logic        rd_chan;
   logic        rd_status;
   logic [2:0]  rd_idx;

   assign miso_sync = miso_sync_q[1];

   always_ff @(posedge xclk or posedge reset) begin
      if (reset) begin
         miso_sync_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
         miso_sync_q <= {miso_sync_q[0], adc_miso};
      end
   end

   assign rd_hit    = bus.read_qualified && (bus.ab[7:4] == ADC_ADDR_NIBBLE) && !reset;
   assign rd_idx    = bus.ab[2:0];
   assign rd_chan   = rd_hit && !bus.ab[3];
   assign rd_status = rd_hit && (bus.ab[3:0] == 4'h8);

   // A store in the same cycle as a read-clear of that channel must leave the flag set.
   always_comb begin
      fresh_d = fresh_q;
      if (rd_chan) fresh_d[rd_idx] = 1'b0;
      if (state_q == STORE) fresh_d[ptr_q] = 1'b1;
   end

   always_ff @(posedge xclk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         half_q  <= '0;
         ptr_q   <= '0;
         shift_q <= '0;
         sclk_q  <= 1'b0;
         cs_n_q  <= '1;
         fresh_q <= '0;
         // NOTE: the sample array is reset on purpose: reads after reset must return zero samples.
         for (int i = 0; i < 8; i++) sample_q[i] <= '0;
      end else begin
         fresh_q <= fresh_d;
         case (state_q)
            IDLE: begin
               if (scan_enable) begin
                  state_q <= CS_SETUP;
                  cs_n_q  <= ~(8'd1 << ptr_q);
                  cnt_q   <= '0;
               end
            end
            CS_SETUP: begin
               if (cnt_q == DIV_LAST) begin
                  state_q <= SHIFT;
                  cnt_q   <= '0;
                  half_q  <= '0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            SHIFT: begin
               if (cnt_q == DIV_LAST) begin
                  cnt_q  <= '0;
                  sclk_q <= ~sclk_q;
                  half_q <= half_q + 5'd1;
                  // Only the low 12 bits of the frame survive; the leading nibble falls off the top.
                  if (!sclk_q) shift_q <= {shift_q[10:0], miso_sync};
                  if (half_q == 5'd31) state_q <= STORE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            STORE: begin
               sample_q[ptr_q] <= shift_q;
               cs_n_q          <= '1;
               ptr_q           <= ptr_q + 3'd1;
               cnt_q           <= '0;
               state_q         <= GAP;
            end
            GAP: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_q <= '0;
                  if (scan_enable) begin
                     state_q <= CS_SETUP;
                     cs_n_q  <= ~(8'd1 << ptr_q);
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      bus.db_out              = 16'h0000;
      bus.data_from_adc_avail = 1'b0;
      if (rd_chan) begin
         bus.db_out              = {fresh_q[rd_idx], rd_idx, sample_q[rd_idx]};
         bus.data_from_adc_avail = 1'b1;
      end else if (rd_status) begin
         bus.db_out              = {8'h00, fresh_q};
         bus.data_from_adc_avail = 1'b1;
      end
   end

   assign adc_sclk  = sclk_q;
   assign adc_cs_n  = cs_n_q;
   assign testpoint = {state_q[1:0], sclk_q, miso_sync};

endmodule

// File: tb/tb_adc_scan_reader.sv
// Bench for adc_scan_reader: serial ADC models, a frame-phase reference model checked every cycle,
// directed scenarios with literal expectations, then randomized scanning and reads.
module tb_adc_scan_reader;

   localparam int CLK_DIV   = 4;
   localparam int SCAN_GAP  = 16;
   localparam int SETUP_LEN = CLK_DIV;
   localparam int STORE_P   = SETUP_LEN + 32 * CLK_DIV;
   localparam int FRAME_LEN = STORE_P + 1 + SCAN_GAP;

   logic       xclk = 1'b0;
   logic       reset = 1'b0;
   logic       scan_enable = 1'b0;
   logic       adc_miso;
   logic       adc_sclk;
   logic [7:0] adc_cs_n;
   logic [3:0] testpoint;

   adc_scan_reader_if bus_if ();

   adc_scan_reader #(
      .CLK_DIV         (CLK_DIV),
      .SCAN_GAP        (SCAN_GAP),
      .ADC_ADDR_NIBBLE (4'hB)
   ) dut (
      .xclk        (xclk),
      .reset       (reset),
      .scan_enable (scan_enable),
      .bus         (bus_if),
      .adc_sclk    (adc_sclk),
      .adc_cs_n    (adc_cs_n),
      .adc_miso    (adc_miso),
      .testpoint   (testpoint)
   );

   always #5 xclk = ~xclk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- serial ADC models ----------------
   logic [15:0] chan_word [8];
   logic [15:0] adc_sr;
   logic        prev_sclk;
   logic [7:0]  prev_cs;

   function automatic int sel_index(input logic [7:0] cs);
      for (int i = 0; i < 8; i++) if (!cs[i]) return i;
      return 0;
   endfunction

   initial begin
      adc_sr    = 16'h0000;
      prev_sclk = 1'b0;
      prev_cs   = 8'hFF;
      adc_miso  = 1'b0;
      forever begin
         @(adc_cs_n or adc_sclk);
         if (adc_cs_n != 8'hFF && prev_cs == 8'hFF)
            adc_sr = chan_word[sel_index(adc_cs_n)];
         else if (adc_cs_n != 8'hFF && prev_sclk && !adc_sclk)
            adc_sr = {adc_sr[14:0], 1'b0};
         adc_miso  = (adc_cs_n != 8'hFF) ? adc_sr[15] : 1'b0;
         prev_cs   = adc_cs_n;
         prev_sclk = adc_sclk;
      end
   end

   // ---------------- reference model: frame phase arithmetic ----------------
   logic        m_run;
   int          m_p;
   int          m_ptr;
   logic [11:0] m_sample [8];
   logic [7:0]  m_fresh;
   logic [15:0] m_word;
   logic [1:0]  m_sync;

   task automatic model_reset();
      m_run   = 1'b0;
      m_p     = 0;
      m_ptr   = 0;
      m_fresh = 8'h00;
      m_word  = 16'h0000;
      m_sync  = 2'b00;
      for (int i = 0; i < 8; i++) m_sample[i] = 12'h000;
   endtask

   task automatic model_step();
      logic hit;
      hit    = bus_if.read_qualified && bus_if.ab[7:4] == 4'hB;
      m_sync = {m_sync[0], adc_miso};
      if (hit && !bus_if.ab[3]) m_fresh[bus_if.ab[2:0]] = 1'b0;
      if (m_run) begin
         if (m_p == STORE_P) begin
            m_sample[m_ptr] = m_word[11:0];
            m_fresh[m_ptr]  = 1'b1;
            m_ptr           = (m_ptr + 1) % 8;
         end
         if (m_p == FRAME_LEN - 1) begin
            if (scan_enable) begin
               m_p    = 0;
               m_word = chan_word[m_ptr];
            end else begin
               m_run = 1'b0;
            end
         end else begin
            m_p++;
         end
      end else if (scan_enable) begin
         m_run  = 1'b1;
         m_p    = 0;
         m_word = chan_word[m_ptr];
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge xclk or posedge reset);
         if (reset) model_reset();
         else model_step();
      end
   end

   // ---------------- per-cycle comparison against the model ----------------
   initial begin
      logic [7:0]  exp_cs;
      logic        exp_sclk;
      logic [15:0] exp_db;
      logic        exp_av;
      logic        hit;
      logic [2:0]  idx;
      forever begin
         @(negedge xclk);
         exp_cs   = (m_run && m_p <= STORE_P) ? ~(8'd1 << m_ptr) : 8'hFF;
         exp_sclk = (m_run && m_p >= SETUP_LEN && m_p < STORE_P) ?
                    (((m_p - SETUP_LEN) / CLK_DIV) % 2 == 1) : 1'b0;
         hit      = bus_if.read_qualified && bus_if.ab[7:4] == 4'hB && !reset;
         idx      = bus_if.ab[2:0];
         exp_db   = 16'h0000;
         exp_av   = 1'b0;
         if (hit && !bus_if.ab[3]) begin
            exp_db = {m_fresh[idx], idx, m_sample[idx]};
            exp_av = 1'b1;
         end else if (hit && bus_if.ab[3:0] == 4'h8) begin
            exp_db = {8'h00, m_fresh};
            exp_av = 1'b1;
         end
         check("cmp_cs", {8'h00, adc_cs_n}, {8'h00, exp_cs});
         check("cmp_sclk", {15'd0, adc_sclk}, {15'd0, exp_sclk});
         check("cmp_db", bus_if.db_out, exp_db);
         check("cmp_avail", {15'd0, bus_if.data_from_adc_avail}, {15'd0, exp_av});
         check("cmp_tp", {14'd0, testpoint[1:0]}, {14'd0, exp_sclk, m_sync[1]});
      end
   end

   // ---------------- directed helpers ----------------
   task automatic step();
      @(posedge xclk);
      #1;
   endtask

   task automatic do_reset();
      reset                 = 1'b1;
      scan_enable           = 1'b0;
      bus_if.read_qualified = 1'b0;
      bus_if.ab             = 8'h00;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input logic [15:0] exp_db, input logic exp_av, input string name);
      bus_if.read_qualified = 1'b1;
      bus_if.ab             = a;
      @(negedge xclk);
      check(name, bus_if.db_out, exp_db);
      check(name, {15'd0, bus_if.data_from_adc_avail}, {15'd0, exp_av});
      step();
      bus_if.read_qualified = 1'b0;
   endtask

   task automatic wait_cs(input logic [7:0] v, input int limit, input string name);
      int n;
      n = 0;
      while (adc_cs_n !== v && n < limit) begin
         step();
         n++;
      end
      check(name, {8'h00, adc_cs_n}, {8'h00, v});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int n_fe;
      int n_rise;
      int n_bad;
      int n;
      logic prev;

      bus_if.read_qualified = 1'b0;
      bus_if.ab             = 8'h00;
      for (int i = 0; i < 8; i++) chan_word[i] = 16'h0000;

      // Reset state
      do_reset();
      @(negedge xclk);
      check("rst_cs", {8'h00, adc_cs_n}, 16'h00FF);
      check("rst_sclk", {15'd0, adc_sclk}, 16'h0000);
      check("rst_db", bus_if.db_out, 16'h0000);
      check("rst_avail", {15'd0, bus_if.data_from_adc_avail}, 16'h0000);
      step();

      // Single channel-0 frame
      chan_word[0] = 16'h0ABC;
      scan_enable  = 1'b1;
      n_fe   = 0;
      n_rise = 0;
      prev   = adc_sclk;
      for (int c = 0; c < 200; c++) begin
         step();
         if (adc_cs_n == 8'hFE) begin
            n_fe++;
            if (adc_sclk && !prev) n_rise++;
         end
         prev = adc_sclk;
      end
      check("t1_cs_low_cycles", 16'(n_fe), 16'd133);
      check("t1_sclk_rises", 16'(n_rise), 16'd16);
      rd(8'hB0, 16'h8ABC, 1'b1, "t1_read_fresh");
      rd(8'hB0, 16'h0ABC, 1'b1, "t1_reread");

      // Full eight-channel scan
      do_reset();
      for (int i = 0; i < 8; i++) chan_word[i] = {4'(i) ^ 4'hA, 12'h100 + 12'(i)};
      scan_enable = 1'b1;
      repeat (8 * FRAME_LEN + 2) step();
      rd(8'hB8, 16'h00FF, 1'b1, "t3_status");
      rd(8'hB7, 16'hF107, 1'b1, "t3_ch7");
      scan_enable = 1'b0;
      repeat (200) step();
      rd(8'hB8, 16'h007F, 1'b1, "t7_status_before");
      rd(8'hB9, 16'h0000, 1'b0, "t7_read_b9");
      rd(8'hA0, 16'h0000, 1'b0, "t7_read_a0");
      rd(8'hBF, 16'h0000, 1'b0, "t7_read_bf");
      rd(8'hB8, 16'h007F, 1'b1, "t7_status_after");

      // scan_enable dropped mid ch2 frame
      do_reset();
      for (int i = 0; i < 8; i++) chan_word[i] = 16'($urandom);
      scan_enable = 1'b1;
      wait_cs(8'hFB, 600, "t4_ch2_start");
      repeat (20) step();
      scan_enable = 1'b0;
      repeat (160) step();
      n_bad = 0;
      for (int c = 0; c < 20; c++) begin
         if (adc_cs_n !== 8'hFF || adc_sclk !== 1'b0) n_bad++;
         step();
      end
      check("t4_idle_static", 16'(n_bad), 16'd0);
      rd(8'hB8, 16'h0007, 1'b1, "t4_status");
      scan_enable = 1'b1;
      step();
      check("t4_resume_ptr3", {8'h00, adc_cs_n}, 16'h00F7);

      // Reset during SHIFT after the 7th rising sclk
      do_reset();
      scan_enable = 1'b1;
      wait_cs(8'hFE, 10, "t5_ch0_start");
      n_rise = 0;
      n      = 0;
      prev   = adc_sclk;
      while (n_rise < 7 && n < 400) begin
         step();
         if (adc_sclk && !prev) n_rise++;
         prev = adc_sclk;
         n++;
      end
      check("t5_rises", 16'(n_rise), 16'd7);
      #1 reset = 1'b1;
      #1;
      check("t5_async_cs", {8'h00, adc_cs_n}, 16'h00FF);
      check("t5_async_sclk", {15'd0, adc_sclk}, 16'h0000);
      scan_enable = 1'b0;
      step();
      reset = 1'b0;
      step();
      rd(8'hB8, 16'h0000, 1'b1, "t5_status");
      for (int i = 0; i < 8; i++)
         rd({5'b10110, 3'(i)}, {1'b0, 3'(i), 12'h000}, 1'b1, "t5_sample_zero");

      // Read of ch5 in its own STORE cycle
      do_reset();
      for (int i = 0; i < 8; i++) chan_word[i] = 16'($urandom);
      chan_word[5] = 16'hE111;
      scan_enable  = 1'b1;
      wait_cs(8'hDF, 1000, "t6_first_ch5");
      repeat (150) step();
      chan_word[5] = 16'h3222;
      wait_cs(8'hDF, 1400, "t6_second_ch5");
      repeat (STORE_P) step();
      bus_if.read_qualified = 1'b1;
      bus_if.ab             = 8'hB5;
      @(negedge xclk);
      check("t6_store_cycle_read", bus_if.db_out, 16'hD111);
      step();
      @(negedge xclk);
      check("t6_next_read", bus_if.db_out, 16'hD222);
      step();
      bus_if.read_qualified = 1'b0;

      // Randomized scanning, enables and reads
      do_reset();
      for (int i = 0; i < 8; i++) chan_word[i] = 16'($urandom);
      scan_enable = 1'b1;
      for (int c = 0; c < 5000; c++) begin
         if ($urandom_range(0, 199) == 0) scan_enable = ~scan_enable;
         if ($urandom_range(0, 99) == 0) chan_word[$urandom_range(0, 7)] = 16'($urandom);
         bus_if.read_qualified = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 3))
            0: bus_if.ab = {4'hB, 4'($urandom)};
            1: bus_if.ab = 8'($urandom);
            2: bus_if.ab = {5'b10110, 3'($urandom)};
            default: bus_if.ab = 8'hB8;
         endcase
         step();
      end
      bus_if.read_qualified = 1'b0;
      scan_enable           = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adc_scan_reader.md
Name: adc_scan_reader

Overview:
- Reader-side companion to the DAC writer path: autonomously scans 8 external 12-bit serial ADCs and deserializes one 16-bit frame per channel.
- Buffers the latest sample per channel and serves DSP bus reads on the address bus.
- Presents the data through the usual app-level db_out / data-available pair; the top level owns bus direction.

Parameters:
- CLK_DIV, 4: xclk cycles per sclk half-period; legal values are 3 to 255.
- SCAN_GAP, 16: xclk cycles with all chip-selects high between frames; legal values are 1 to 255.
- ADC_ADDR_NIBBLE, 4'hB: value of ab[7:4] that selects this block for reads.

Ports:
- xclk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- scan_enable  in  1  1 = run the continuous round-robin scan.
- read_qualified  in  1  bus read strobe, one xclk wide.
- ab  in  8  address bus.
- db_out  out  16  read data to the top-level bus mux.
- data_from_adc_avail  out  1  1 when db_out is valid for the current read.
- adc_sclk  out  1  serial clock shared by all ADCs; idles low.
- adc_cs_n  out  8  per-channel chip-select, active low.
- adc_miso  in  1  shared serial data from the ADCs, MSB first.
- testpoint  out  4  debug: {state[1:0], adc_sclk, adc_miso_sync}.

Behaviour:
- Clock and reset: one clock (xclk); reset is asynchronous and active-high.
- Reset values:
  - adc_sclk=0, adc_cs_n=8'hFF.
  - All 8 sample registers = 12'h000; all fresh flags = 0.
  - Channel pointer = 0; state = IDLE.
  - db_out = 16'h0000; data_from_adc_avail = 0.
- Reset asserted mid-frame: adc_cs_n goes to 8'hFF and adc_sclk to 0 immediately (asynchronously). The partial frame is discarded.
- adc_miso passes through a 2-flop synchronizer to form adc_miso_sync.
- State machine:
  - IDLE: adc_cs_n=8'hFF. If scan_enable=1, move to CS_SETUP on the next edge.
  - CS_SETUP: adc_cs_n[ptr]=0 and adc_sclk=0 for CLK_DIV cycles, then SHIFT.
  - SHIFT: adc_sclk toggles every CLK_DIV cycles, 16 full periods (32*CLK_DIV cycles). On each xclk edge that drives adc_sclk 0->1, adc_miso_sync shifts into a 16-bit shift register, MSB first. After the 16th rising edge, the low half completes with sclk ending at 0, then STORE.
  - STORE (1 cycle): sample[ptr] <= shift[11:0] (bits [15:12] are ignored); fresh[ptr] <= 1; adc_cs_n <= 8'hFF; ptr <= ptr+1, wrapping 7->0. Then GAP.
  - GAP: SCAN_GAP cycles with all chip-selects high. Then CS_SETUP if scan_enable=1, else IDLE.
- Deasserting scan_enable mid-frame does not abort; the current frame completes and stores.
- Frame period = CLK_DIV + 32*CLK_DIV + 1 + SCAN_GAP xclk cycles (149 with defaults). A full 8-channel scan takes 8x that.
- Reads are combinational decode; a read is valid when read_qualified=1 and ab[7:4]=ADC_ADDR_NIBBLE:
  - ab[3]=0: data_from_adc_avail=1; db_out = {fresh[ab[2:0]], ab[2:0], sample[ab[2:0]]}. On that xclk edge fresh[ab[2:0]] clears.
  - ab[3:0]=4'h8: status read; db_out = {8'h00, fresh[7:0]}; avail=1; no flags change.
  - ab[3:0] = 9..F: avail=0, db_out=0.
  - Any non-matching cycle: avail=0, db_out=16'h0000.
- Simultaneous STORE and read of the same channel: the read returns the old sample and old flag; after the edge the new sample is stored and fresh=1 (store wins).
- Only one adc_cs_n bit is ever low at a time. adc_sclk never toggles while all chip-selects are high.

Test Plan:
- Reset, then scan_enable=1, with the ADC model on ch0 returning 16'h0ABC. Required: adc_cs_n=8'hFE for 133 cycles; 16 rising sclk edges; a read at ab=8'hB0 returns 16'h8ABC; an immediate re-read returns 16'h0ABC.
- Full scan with channel n returning 12'h100+n, after 8*149 cycles. Required: status read ab=8'hB8 returns 16'h00FF; ab=8'hB7 returns 16'hF107.
- scan_enable dropped 20 cycles into the ch2 frame. Required: the ch2 frame completes and stores, then IDLE with adc_cs_n=8'hFF and adc_sclk static low; ptr=3 on re-enable.
- Reset asserted in SHIFT at bit 7. Required: same-cycle adc_cs_n=8'hFF and adc_sclk=0; all samples 0; status reads 16'h0000.
- Read of ch5 issued in the STORE cycle of ch5 (old 12'h111, new 12'h222). Required: db_out=16'hD111 that cycle if fresh was set (16'h5111 if not); the next read returns 16'hD222.
- Reads at ab=8'hB9 and 8'hA0. Required: data_from_adc_avail=0 and db_out=16'h0000; no fresh flag changes.
